prog_launcher: RTL and testbench

- Initiator side of the core's Start/Done program-launch handshake; the core's program counter is the responder.
- Sequences NUM_PROGS programs back-to-back: pulses Start, waits for the core's Done, records per-program cycle count, advances.
- Sits between the test harness (Go, result readout) and the processor top (Start, Done); also usable as the on-board launch controller.

---
 rtl/prog_launcher.sv | 152 +++++++++++++++
 tb/tb_prog_launcher.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_launcher.sv
// prog_launcher: initiator side of the Start/Done program-launch handshake.
// Launches NUM_PROGS programs back-to-back on each Go, times each program's
// RUN phase, and reports the per-program cycle count with a one-cycle strobe.
module prog_launcher #(
  parameter int unsigned NUM_PROGS  = 3,
  parameter int unsigned START_HOLD = 1,
  parameter int unsigned CW         = 16,
  parameter logic [CW-1:0] TIMEOUT  = 16'd4000,
  localparam int unsigned IW = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Go,
  input  logic          Done,
  output logic          Start,
  output logic          Busy,
  output logic [IW-1:0] ProgIdx,
  output logic [CW-1:0] CycleCount,
  output logic          CycleValid,
  output logic          Timeout,
  output logic          AllDone
);

  // Hold counter only needs to reach START_HOLD-1.
  localparam int unsigned HW = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_PROGS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_RECORD = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_prog_idx;
  logic [HW-1:0] r_hold;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_cycle_count;
  logic          r_timeout;
  logic          r_start;
  logic          r_busy;
  logic          r_cycle_valid;
  logic          r_all_done;

  state_t        w_state_nxt;
  logic [IW-1:0] w_prog_idx_nxt;
  logic [HW-1:0] w_hold_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cycle_count_nxt;
  logic          w_timeout_nxt;
  logic [CW-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CW'(1);

  // Next-state and next-datapath decode; outputs are derived from the next state.
  always_comb begin
    w_state_nxt       = r_state;
    w_prog_idx_nxt    = r_prog_idx;
    w_hold_nxt        = r_hold;
    w_cnt_nxt         = r_cnt;
    w_cycle_count_nxt = r_cycle_count;
    w_timeout_nxt     = r_timeout;

    case (r_state)
      S_IDLE, S_FINISH: begin
        if (Go) begin
          w_state_nxt    = S_LAUNCH;
          w_prog_idx_nxt = '0;
          w_timeout_nxt  = 1'b0;
          w_hold_nxt     = '0;
        end
      end

      S_LAUNCH: begin
        if (r_hold == HOLD_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_hold_nxt = r_hold + HW'(1);
        end
      end

      S_RUN: begin
        // Done takes priority over a coincident timeout.
        if (Done) begin
          w_state_nxt       = S_RECORD;
          w_cycle_count_nxt = w_cnt_inc;
        end else if (w_cnt_inc == TIMEOUT) begin
          w_state_nxt       = S_RECORD;
          w_cycle_count_nxt = TIMEOUT;
          w_timeout_nxt     = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      S_RECORD: begin
        if (r_prog_idx == IDX_LAST) begin
          w_state_nxt = S_FINISH;
        end else begin
          w_state_nxt    = S_LAUNCH;
          w_prog_idx_nxt = r_prog_idx + IW'(1);
          w_hold_nxt     = '0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered-output update; synchronous reset wins.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_prog_idx    <= '0;
      r_hold        <= '0;
      r_cnt         <= '0;
      r_cycle_count <= '0;
      r_timeout     <= 1'b0;
      r_start       <= 1'b0;
      r_busy        <= 1'b0;
      r_cycle_valid <= 1'b0;
      r_all_done    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_prog_idx    <= w_prog_idx_nxt;
      r_hold        <= w_hold_nxt;
      r_cnt         <= w_cnt_nxt;
      r_cycle_count <= w_cycle_count_nxt;
      r_timeout     <= w_timeout_nxt;
      r_start       <= (w_state_nxt == S_LAUNCH);
      r_busy        <= (w_state_nxt == S_LAUNCH) || (w_state_nxt == S_RUN) ||
                       (w_state_nxt == S_RECORD);
      r_cycle_valid <= (w_state_nxt == S_RECORD);
      r_all_done    <= (w_state_nxt == S_FINISH);
    end
  end

  assign Start      = r_start;
  assign Busy       = r_busy;
  assign ProgIdx    = r_prog_idx;
  assign CycleCount = r_cycle_count;
  assign CycleValid = r_cycle_valid;
  assign Timeout    = r_timeout;
  assign AllDone    = r_all_done;

endmodule

// File: tb/tb_prog_launcher.sv
// Self-checking bench for prog_launcher: cycle-by-cycle vector table plus
// hand-written multi-cycle handshake sequences.
module tb_prog_launcher;

  localparam int unsigned NP = 3;
  localparam int unsigned CW = 16;
  localparam int unsigned TO = 20;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Go = 1'b0;
  logic          Done = 1'b0;
  logic          Start;
  logic          Busy;
  logic [1:0]    ProgIdx;
  logic [CW-1:0] CycleCount;
  logic          CycleValid;
  logic          Timeout;
  logic          AllDone;

  int n_checks = 0;
  int n_errors = 0;

  prog_launcher #(
    .NUM_PROGS (NP),
    .START_HOLD(1),
    .CW        (CW),
    .TIMEOUT   (16'd20)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Go        (Go),
    .Done      (Done),
    .Start     (Start),
    .Busy      (Busy),
    .ProgIdx   (ProgIdx),
    .CycleCount(CycleCount),
    .CycleValid(CycleValid),
    .Timeout   (Timeout),
    .AllDone   (AllDone)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic rst;
    logic go;
    logic done;
    logic e_start;
    logic e_busy;
    logic e_valid;
    logic e_all;
    logic e_to;
    int   e_idx;
    int   e_cc;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input vec_t v);
    chk({nm, " Start"},      32'(Start),      32'(v.e_start));
    chk({nm, " Busy"},       32'(Busy),       32'(v.e_busy));
    chk({nm, " CycleValid"}, 32'(CycleValid), 32'(v.e_valid));
    chk({nm, " AllDone"},    32'(AllDone),    32'(v.e_all));
    chk({nm, " Timeout"},    32'(Timeout),    32'(v.e_to));
    chk({nm, " ProgIdx"},    32'(ProgIdx),    32'(v.e_idx));
    chk({nm, " CycleCount"}, 32'(CycleCount), 32'(v.e_cc));
  endtask

  // Core model for one program: wait for Start, then complete after n RUN cycles
  // (or never, if give_done is 0), then check the recorded result.
  task automatic run_prog(input string nm, input int n, input bit give_done,
                          input int exp_idx, input int exp_cc, input logic exp_to);
    int k;
    k = 0;
    while (!Start && k < 50) begin @(negedge Clk); k++; end
    chk({nm, " start seen"}, 32'(Start), 32'd1);
    chk({nm, " launch idx"}, 32'(ProgIdx), 32'(exp_idx));
    k = 0;
    while (Start && k < 50) begin @(negedge Clk); k++; end
    chk({nm, " start fell"}, 32'(Start), 32'd0);
    if (give_done) begin
      repeat (n - 1) @(negedge Clk);
      Done = 1'b1;
    end
    k = 0;
    @(negedge Clk);
    while (!CycleValid && k < 100) begin @(negedge Clk); k++; end
    chk({nm, " CycleValid"}, 32'(CycleValid), 32'd1);
    chk({nm, " ProgIdx"},    32'(ProgIdx),    32'(exp_idx));
    chk({nm, " CycleCount"}, 32'(CycleCount), 32'(exp_cc));
    chk({nm, " Timeout"},    32'(Timeout),    32'(exp_to));
    Done = 1'b0;
  endtask

  task automatic pulse_go();
    Go = 1'b1;
    @(negedge Clk);
    Go = 1'b0;
  endtask

  initial begin
    //           rst go dn  st bz vl al to idx cc
    vecs[0]  = '{1, 0, 0,  0, 0, 0, 0, 0, 0, 0};  // reset
    vecs[1]  = '{0, 1, 0,  1, 1, 0, 0, 0, 0, 0};  // Go -> LAUNCH
    vecs[2]  = '{0, 0, 0,  0, 1, 0, 0, 0, 0, 0};  // RUN
    vecs[3]  = '{0, 0, 1,  0, 1, 1, 0, 0, 0, 1};  // Done on 1st RUN cycle
    vecs[4]  = '{0, 0, 1,  1, 1, 0, 0, 0, 1, 1};  // LAUNCH prog1, Done held
    vecs[5]  = '{0, 0, 1,  0, 1, 0, 0, 0, 1, 1};  // Done ignored in LAUNCH
    vecs[6]  = '{0, 0, 1,  0, 1, 1, 0, 0, 1, 1};  // held Done completes, cc=1
    vecs[7]  = '{0, 0, 0,  1, 1, 0, 0, 0, 2, 1};  // LAUNCH prog2
    vecs[8]  = '{0, 1, 0,  0, 1, 0, 0, 0, 2, 1};  // Go in LAUNCH ignored
    vecs[9]  = '{0, 1, 0,  0, 1, 0, 0, 0, 2, 1};  // Go in RUN ignored
    vecs[10] = '{0, 0, 1,  0, 1, 1, 0, 0, 2, 2};  // Done on 2nd RUN cycle
    vecs[11] = '{0, 0, 0,  0, 0, 0, 1, 0, 2, 2};  // FINISH
    vecs[12] = '{0, 0, 0,  0, 0, 0, 1, 0, 2, 2};  // FINISH holds
    vecs[13] = '{0, 1, 0,  1, 1, 0, 0, 0, 0, 2};  // Go in FINISH restarts
    vecs[14] = '{1, 0, 0,  0, 0, 0, 0, 0, 0, 0};  // reset in LAUNCH
    vecs[15] = '{0, 0, 1,  0, 0, 0, 0, 0, 0, 0};  // Done ignored in IDLE

    @(negedge Clk);
    for (int i = 0; i < 16; i++) begin
      Reset = vecs[i].rst;
      Go    = vecs[i].go;
      Done  = vecs[i].done;
      @(negedge Clk);
      chk_all($sformatf("vec%0d", i), vecs[i]);
    end
    Reset = 1'b0;
    Go    = 1'b0;
    Done  = 1'b0;
    @(negedge Clk);

    // Three programs, each finishing 10 RUN cycles after Start falls.
    pulse_go();
    chk("A go->start", 32'(Start), 32'd1);
    chk("A busy", 32'(Busy), 32'd1);
    for (int p = 0; p < 3; p++)
      run_prog($sformatf("A p%0d", p), 10, 1'b1, p, 10, 1'b0);
    @(negedge Clk);
    chk("A AllDone", 32'(AllDone), 32'd1);
    chk("A Busy",    32'(Busy),    32'd0);
    chk("A Timeout", 32'(Timeout), 32'd0);
    chk("A idx",     32'(ProgIdx), 32'd2);

    // Program 1 times out; Timeout stays set through program 2.
    pulse_go();
    run_prog("B p0", 5, 1'b1, 0, 5, 1'b0);
    run_prog("B p1", 0, 1'b0, 1, TO, 1'b1);
    run_prog("B p2", 3, 1'b1, 2, 3, 1'b1);
    @(negedge Clk);
    chk("B AllDone", 32'(AllDone), 32'd1);
    chk("B Timeout", 32'(Timeout), 32'd1);

    // Go in FINISH restarts at index 0 with Timeout and AllDone cleared.
    pulse_go();
    chk("C AllDone", 32'(AllDone), 32'd0);
    chk("C Timeout", 32'(Timeout), 32'd0);
    chk("C idx",     32'(ProgIdx), 32'd0);
    chk("C start",   32'(Start),   32'd1);
    // Done and timeout coincide: Done wins.
    run_prog("C p0", TO, 1'b1, 0, TO, 1'b0);

    // Reset during RUN of program 1 aborts without a CycleValid.
    while (!Start) @(negedge Clk);
    @(negedge Clk);
    chk("D in run", 32'(Busy & ~Start), 32'd1);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("D Busy",       32'(Busy),       32'd0);
    chk("D Start",      32'(Start),      32'd0);
    chk("D CycleValid", 32'(CycleValid), 32'd0);
    chk("D idx",        32'(ProgIdx),    32'd0);
    chk("D CycleCount", 32'(CycleCount), 32'd0);
    chk("D AllDone",    32'(AllDone),    32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("D idle", 32'(Busy), 32'd0);
    pulse_go();
    chk("D restart start", 32'(Start),   32'd1);
    chk("D restart idx",   32'(ProgIdx), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
